// File: rtl/wb_sram_slave.sv
// Wishbone classic single-beat slave driving one asynchronous 32-bit SRAM bank.
// Every output is registered; reads and writes are sequenced through a small FSM.
module wb_sram_slave #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int SRAM_ADDR_WIDTH = 20,
    parameter int SRAM_DATA_WIDTH = 32,
    parameter int WAIT_CYCLES     = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         wb_cyc_i,
    input  logic                         wb_stb_i,
    output logic                         wb_ack_o,
    input  logic [ADDR_WIDTH-1:0]        wb_adr_i,
    input  logic [DATA_WIDTH-1:0]        wb_dat_i,
    output logic [DATA_WIDTH-1:0]        wb_dat_o,
    input  logic [DATA_WIDTH/8-1:0]      wb_sel_i,
    input  logic                         wb_we_i,
    output logic [SRAM_ADDR_WIDTH-1:0]   sram_addr,
    input  logic [SRAM_DATA_WIDTH-1:0]   sram_data_i,
    output logic [SRAM_DATA_WIDTH-1:0]   sram_data_o,
    output logic                         sram_data_oe,
    output logic                         sram_ce_n,
    output logic                         sram_oe_n,
    output logic                         sram_we_n,
    output logic [SRAM_DATA_WIDTH/8-1:0] sram_be_n
);

    localparam int BE_W  = SRAM_DATA_WIDTH / 8;
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ_WAIT,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        DONE
    } state_t;

    state_t                       state_q, state_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic                         aborted_q, aborted_d;
    logic                         ack_q, ack_d;
    logic [DATA_WIDTH-1:0]        dat_o_q, dat_o_d;
    logic [SRAM_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [SRAM_DATA_WIDTH-1:0]   data_o_q, data_o_d;
    logic                         data_oe_q, data_oe_d;
    logic                         ce_n_q, ce_n_d;
    logic                         oe_n_q, oe_n_d;
    logic                         we_n_q, we_n_d;
    logic [BE_W-1:0]              be_n_q, be_n_d;

    logic req;
    logic cnt_done;
    logic wr_drop;
    logic unused_adr_bits;

    assign req      = wb_cyc_i & wb_stb_i;
    assign cnt_done = (cnt_q == CNT_LAST);
    // A write whose cycle was dropped after setup still finishes its pulse, silently.
    assign wr_drop  = aborted_q | ~wb_cyc_i;
    assign unused_adr_bits = ^{wb_adr_i[ADDR_WIDTH-1:SRAM_ADDR_WIDTH+2], wb_adr_i[1:0]};

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            aborted_q <= 1'b0;
            ack_q     <= 1'b0;
            dat_o_q   <= '0;
            addr_q    <= '0;
            data_o_q  <= '0;
            data_oe_q <= 1'b0;
            ce_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            be_n_q    <= '1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            aborted_q <= aborted_d;
            ack_q     <= ack_d;
            dat_o_q   <= dat_o_d;
            addr_q    <= addr_d;
            data_o_q  <= data_o_d;
            data_oe_q <= data_oe_d;
            ce_n_q    <= ce_n_d;
            oe_n_q    <= oe_n_d;
            we_n_q    <= we_n_d;
            be_n_q    <= be_n_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        aborted_d = aborted_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d   = wb_we_i ? WR_SETUP : READ_WAIT;
                    cnt_d     = '0;
                    aborted_d = 1'b0;
                end
            end
            READ_WAIT: begin
                if (!wb_cyc_i) begin
                    state_d = IDLE;
                end else if (cnt_done) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WR_SETUP: begin
                if (!wb_cyc_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = WR_PULSE;
                    cnt_d   = '0;
                end
            end
            WR_PULSE: begin
                aborted_d = wr_drop;
                if (cnt_done) begin
                    state_d = WR_HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WR_HOLD: begin
                state_d = wr_drop ? IDLE : DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        ack_d     = 1'b0;
        dat_o_d   = dat_o_q;
        addr_d    = addr_q;
        data_o_d  = data_o_q;
        data_oe_d = data_oe_q;
        ce_n_d    = ce_n_q;
        oe_n_d    = oe_n_q;
        we_n_d    = we_n_q;
        be_n_d    = be_n_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d = wb_adr_i[SRAM_ADDR_WIDTH+1:2];
                    be_n_d = ~wb_sel_i;
                    ce_n_d = 1'b0;
                    we_n_d = 1'b1;
                    if (wb_we_i) begin
                        data_o_d  = wb_dat_i;
                        data_oe_d = 1'b1;
                        oe_n_d    = 1'b1;
                    end else begin
                        data_oe_d = 1'b0;
                        oe_n_d    = 1'b0;
                    end
                end
            end
            READ_WAIT: begin
                if (!wb_cyc_i || cnt_done) begin
                    ce_n_d = 1'b1;
                    oe_n_d = 1'b1;
                    be_n_d = '1;
                    if (wb_cyc_i) begin
                        dat_o_d = sram_data_i;
                        ack_d   = 1'b1;
                    end
                end
            end
            WR_SETUP: begin
                if (!wb_cyc_i) begin
                    ce_n_d    = 1'b1;
                    data_oe_d = 1'b0;
                    be_n_d    = '1;
                end else begin
                    we_n_d = 1'b0;
                end
            end
            WR_PULSE: begin
                if (cnt_done) begin
                    we_n_d = 1'b1;
                end
            end
            WR_HOLD: begin
                ce_n_d    = 1'b1;
                data_oe_d = 1'b0;
                be_n_d    = '1;
                ack_d     = ~wr_drop;
            end
            default: begin
            end
        endcase
    end

    assign wb_ack_o     = ack_q;
    assign wb_dat_o     = dat_o_q;
    assign sram_addr    = addr_q;
    assign sram_data_o  = data_o_q;
    assign sram_data_oe = data_oe_q;
    assign sram_ce_n    = ce_n_q;
    assign sram_oe_n    = oe_n_q;
    assign sram_we_n    = we_n_q;
    assign sram_be_n    = be_n_q;

endmodule

// File: doc/wb_sram_slave.md
Name: wb_sram_slave

Overview:
- Wishbone classic single-beat slave. Serves the CPU's IF and MEM-stage Wishbone masters by driving one external asynchronous 32-bit SRAM bank.
- Converts byte-addressed Wishbone reads and writes into timed SRAM strobe sequences. Returns one registered ack per transfer.
- Sits between the bus arbiter/mux and the SRAM pins. The top level handles tri-state via a split data bus plus an output enable.

Parameters:
- ADDR_WIDTH, 32, Wishbone address width.
- DATA_WIDTH, 32, Wishbone data width; must equal SRAM_DATA_WIDTH.
- SRAM_ADDR_WIDTH, 20, SRAM word-address width.
- SRAM_DATA_WIDTH, 32, SRAM data width.
- WAIT_CYCLES, 1, number of SRAM access cycles (>=1) for the read-data-valid window and for the we_n low pulse.

Ports:
- clk_i  in  1  clock; all logic on its rising edge.
- rst_i  in  1  reset: synchronous, active-low.
- wb_cyc_i  in  1  bus cycle valid.
- wb_stb_i  in  1  transfer strobe.
- wb_ack_o  out  1  transfer done, one-cycle pulse.
- wb_adr_i  in  ADDR_WIDTH  byte address.
- wb_dat_i  in  DATA_WIDTH  write data.
- wb_dat_o  out  DATA_WIDTH  read data, valid while ack=1.
- wb_sel_i  in  DATA_WIDTH/8  byte lanes.
- wb_we_i  in  1  1=write, 0=read.
- sram_addr  out  SRAM_ADDR_WIDTH  word address.
- sram_data_i  in  SRAM_DATA_WIDTH  data from pins.
- sram_data_o  out  SRAM_DATA_WIDTH  data to pins.
- sram_data_oe  out  1  1=drive pins.
- sram_ce_n  out  1  chip enable, low active.
- sram_oe_n  out  1  output enable, low active.
- sram_we_n  out  1  write enable, low active.
- sram_be_n  out  SRAM_DATA_WIDTH/8  byte enables, low active.

Behaviour:
- All outputs are registered.
- Reset value (rst_i=0 at an edge):
  - ack=0, wb_dat_o=0, sram_addr=0, sram_data_o=0, sram_data_oe=0.
  - ce_n=1, oe_n=1, we_n=1, be_n=all ones.
  - State IDLE.
- Reset asserted mid-transfer: at that edge, all strobes deassert, no ack is issued, and the transfer is dropped.
- Request capture (IDLE, cyc&stb sampled at edge k):
  - Latch sram_addr = wb_adr_i[SRAM_ADDR_WIDTH+1:2]; adr[1:0] is ignored.
  - Latch be_n = ~wb_sel_i.
  - Set ce_n=0.
- READ path (we=0):
  - At edge k: oe_n=0, data_oe=0. Enter READ_WAIT and hold for WAIT_CYCLES cycles.
  - At edge k+WAIT_CYCLES: capture wb_dat_o <= sram_data_i; ce_n=1, oe_n=1, be_n=1s; ack=1; state DONE.
  - Ack is visible in the cycle after edge k+WAIT_CYCLES.
- WRITE path (we=1):
  - At edge k: sram_data_o <= wb_dat_i, data_oe=1, we_n=1 (address/data setup). State WR_SETUP.
  - At edge k+1: we_n=0 for WAIT_CYCLES cycles (WR_PULSE).
  - Then we_n=1 with ce_n and data still driven for one cycle (WR_HOLD).
  - At edge k+WAIT_CYCLES+2: ce_n=1, data_oe=0, be_n=1s, ack=1, state DONE.
- DONE:
  - ack returns to 0 at the next edge and the state goes to IDLE.
  - A still-high stb is not a new request until sampled in IDLE, so back-to-back transfers have at least one idle cycle between acks.
- oe_n and we_n are never low in the same cycle. data_oe=1 never overlaps oe_n=0.
- cyc dropped mid-transfer:
  - Read: abort at the next edge, deassert all strobes, return to IDLE, no ack.
  - Write: once past WR_SETUP, complete the we pulse and hold, with ack suppressed (no partial write glitch).
  - Write dropped during WR_SETUP: abort as for a read.
- wb_sel_i=0 write: full strobe sequence runs with be_n=1111; ack is issued normally.
- wb_dat_o holds its last read value until the next read completes.

Test Plan:
- Reset: hold rst_i=0 for 3 cycles with stb=1 -> ack never 1, ce_n/oe_n/we_n=1, data_oe=0, be_n=1111.
- Read, WAIT_CYCLES=1: SRAM model holds 0xDEADBEEF at word 0x00040; request adr=0x0000_0100 sel=1111 -> sram_addr=0x00040, oe_n=0 for 1 cycle, ack one cycle later with wb_dat_o=0xDEADBEEF, ack high exactly 1 cycle.
- Byte write: adr=0x0000_0207, dat=0x000000AB, sel=0001 -> sram_addr=0x00081, be_n=1110, we_n low 1 cycle inside the ce_n window with data driven, ack at edge k+3; read-back gives only byte0=0xAB.
- Back-to-back: write 0x12345678 to 0x10 then read 0x10 with stb held high -> two acks separated by at least 1 idle cycle, read returns 0x12345678, no oe_n/we_n overlap.
- Abort: start a read with WAIT_CYCLES=3, drop cyc after 1 cycle -> all strobes high next edge, no ack; the following request completes normally.
- Reset mid-write: assert rst_i=0 during WR_PULSE -> we_n=1, ce_n=1, data_oe=0 at that edge, no ack.
